// File: rtl/mux_rr_arbiter.sv
// Round-robin grant controller that drives the select input of a shared N:1 data mux.
// Optional stall timeout, enabled by defining MUX_ARB_TIMEOUT_EN, adds the timeout_pulse port.
module mux_rr_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         data_in,
    input  logic                   out_ready,
    output logic [N-1:0]           gnt,
    output logic [$clog2(N)-1:0]   sel,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
`ifdef MUX_ARB_TIMEOUT_EN
    output logic                   timeout_pulse,
`endif
    output logic                   busy
);

    localparam int unsigned SW = $clog2(N);

    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mux_rr_arbiter: N must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic            busy_q, busy_d;
    logic [N-1:0]    others_c;
    logic            valid_c;
    logic [W-1:0]    din [N];

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tpulse_q, tpulse_d;
`endif

    // First set bit of mask strictly after ptr, wrapping past N-1 back to 0.
    function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] mask, input logic [SW-1:0] ptr);
        logic [SW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && mask[SW'(idx)]) begin
                pick  = SW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [SW-1:0] s);
        return N'(1) << s;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_din
        assign din[i] = data_in[i*W +: W];
    end

    assign others_c  = req & ~gnt_q;
    assign valid_c   = (state_q == S_GRANT) && req[sel_q];

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign out_valid = valid_c;
    assign out_data  = din[sel_q];
`ifdef MUX_ARB_TIMEOUT_EN
    assign timeout_pulse = tpulse_q;
`endif

    // Next-state and grant policy.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef MUX_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tpulse_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    sel_d   = rr_pick(req, ptr_q);
                    gnt_d   = onehot(sel_d);
                    state_d = S_GRANT;
`ifdef MUX_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_GRANT: begin
                if (!req[sel_q]) begin
                    // Withdrawal before transfer: release and fall back to IDLE.
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q;
                end else if (out_ready) begin
                    // Transfer; hand over in the same edge if anyone else waits.
                    ptr_d = sel_q;
                    if (|others_c) begin
                        sel_d = rr_pick(others_c, sel_q);
                        gnt_d = onehot(sel_d);
                    end
`ifdef MUX_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
`ifdef MUX_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    ptr_d    = sel_q;
                    tpulse_d = 1'b1;
                    cnt_d    = '0;
                    if (|others_c) begin
                        sel_d = rr_pick(others_c, sel_q);
                        gnt_d = onehot(sel_d);
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d == S_GRANT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            ptr_q    <= SW'(N - 1);
            busy_q   <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            tpulse_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tpulse_q <= tpulse_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: per-cycle model comparison plus directed literal checks.
module tb_mux_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = $clog2(N);

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   data_in;
    logic             out_ready;
    logic [N-1:0]     gnt;
    logic [SW-1:0]    sel;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             busy;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam int TO = 16;
    logic             timeout_pulse;
    int               m_cnt;
`endif

    int n_run  = 0;
    int n_fail = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(N), .W(W)
`ifdef MUX_ARB_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .out_ready(out_ready),
        .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data),
`ifdef MUX_ARB_TIMEOUT_EN
        .timeout_pulse(timeout_pulse),
`endif
        .busy(busy)
    );

    // Model: owner index (-1 when nobody holds the mux), last-served pointer, mux select.
    int           m_own, m_ptr, m_sel;
    logic         m_pulse;
    logic [N-1:0] m_oth;

    function automatic int next_after(int p, logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_own = -1; m_ptr = N - 1; m_sel = 0; m_pulse = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            m_cnt = 0;
`endif
        end else begin
            m_pulse = 1'b0;
            if (m_own < 0) begin
                if (req != 0) begin
                    m_own = next_after(m_ptr, req);
                    m_sel = m_own;
`ifdef MUX_ARB_TIMEOUT_EN
                    m_cnt = 0;
`endif
                end
            end else if (!req[m_own]) begin
                m_ptr = m_own;
                m_own = -1;
            end else begin
                m_oth = req;
                m_oth[m_own] = 1'b0;
                if (out_ready) begin
                    m_ptr = m_own;
                    if (m_oth != 0) m_own = next_after(m_ptr, m_oth);
                    m_sel = m_own;
`ifdef MUX_ARB_TIMEOUT_EN
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == TO) begin
                        m_ptr = m_own; m_pulse = 1'b1; m_cnt = 0;
                        if (m_oth != 0) begin
                            m_own = next_after(m_ptr, m_oth);
                            m_sel = m_own;
                        end else begin
                            m_own = -1;
                        end
                    end
`endif
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic         ev;
        logic [W-1:0] ed;
        logic         bad;
        if (!rst && chk_on) begin
            eg  = (m_own < 0) ? '0 : (N'(1) << m_own);
            ev  = (m_own >= 0) && req[m_own];
            ed  = data_in[m_sel*W +: W];
            bad = (gnt !== eg) || (sel !== SW'(m_sel)) || (busy !== (m_own >= 0)) ||
                  (out_valid !== ev) || (out_data !== ed);
`ifdef MUX_ARB_TIMEOUT_EN
            bad = bad || (timeout_pulse !== m_pulse);
`endif
            n_run++;
            if (bad) begin
                n_fail++;
                $display("FAIL model t=%0t gnt=%b exp %b sel=%0d exp %0d busy=%b valid=%b exp %b data=%h exp %h",
                         $time, gnt, eg, sel, m_sel, busy, out_valid, ev, out_data, ed);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1; req = '0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    logic [4:0] tbl [16] = '{5'b1010_1, 5'b1010_0, 5'b1010_1, 5'b0110_1,
                             5'b0110_0, 5'b0111_1, 5'b0001_1, 5'b0000_1,
                             5'b1001_0, 5'b1001_1, 5'b1101_1, 5'b0100_0,
                             5'b0000_0, 5'b1111_0, 5'b1111_1, 5'b0000_1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b0;
        data_in = {8'h33, 8'h22, 8'h11, 8'hA5};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        #1 rst = 1'b0; chk_on = 1'b1;

        // Single requester: grant one cycle later, transfer, release after req drops.
        tick(); req = 4'b0001; out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_sel", 32'(sel), 0);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_data", 32'(out_data), 32'hA5);
        tick(); req = 4'b0000;
        tick();
        @(negedge clk);
        chk("t1_release", 32'(gnt), 0);
        chk("t1_idle_busy", 32'(busy), 0);

        // All requesting: strict rotation with no idle cycle.
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            chk("t2_rr_sel", 32'(sel), 32'(i % 4));
            chk("t2_busy", 32'(busy), 1);
        end
        #1 req = 4'b0000; out_ready = 1'b0;

        // Stall for 5 cycles, then transfer and hand over to requester 2.
        do_reset();
        req = 4'b0101; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("t3_stall_gnt", 32'(gnt), 32'h1);
            chk("t3_stall_valid", 32'(out_valid), 1);
        end
        #1 out_ready = 1'b1;
        tick(); req = 4'b0100;
        @(negedge clk);
        chk("t3_next_gnt", 32'(gnt), 32'h4);
        chk("t3_next_data", 32'(out_data), 32'h22);

        // Withdrawal by requester 2 while requester 3 waits.
        #1 out_ready = 1'b0; req = 4'b1100;
        tick();
        @(negedge clk);
        chk("t4_hold_gnt", 32'(gnt), 32'h4);
        #1 req = 4'b1000;
        #1 chk("t4_valid_drop", 32'(out_valid), 0);
        tick();
        @(negedge clk);
        chk("t4_idle_gnt", 32'(gnt), 0);
        chk("t4_idle_busy", 32'(busy), 0);
        tick();
        @(negedge clk);
        chk("t4_gnt3", 32'(gnt), 32'h8);
        chk("t4_data3", 32'(out_data), 32'h33);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 4'b0010; out_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_sel", 32'(sel), 1);
        chk("t5_valid", 32'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_gnt", 32'(gnt), 0);
        chk("t5_async_valid", 32'(out_valid), 0);
        chk("t5_async_busy", 32'(busy), 0);
        tick();
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_regrant", 32'(gnt), 32'h2);

        // Mixed request/ready pattern, checked by the per-cycle model.
        for (int i = 0; i < 16; i++) begin
            tick();
            req       = tbl[i][4:1];
            out_ready = tbl[i][0];
            data_in   = {data_in[23:0], data_in[31:24]};
        end
        tick(); req = '0; out_ready = 1'b0;
        tick();

`ifdef MUX_ARB_TIMEOUT_EN
        // Stalled grant is revoked after TIMEOUT cycles and handed to requester 1.
        do_reset();
        req = 4'b0011; out_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tick();
            @(negedge clk);
            chk("t6_hold_gnt", 32'(gnt), 32'h1);
            chk("t6_no_pulse", 32'(timeout_pulse), 0);
        end
        tick();
        @(negedge clk);
        chk("t6_pulse", 32'(timeout_pulse), 1);
        chk("t6_moved_gnt", 32'(gnt), 32'h2);
        tick();
        @(negedge clk);
        chk("t6_pulse_clear", 32'(timeout_pulse), 0);
        #1 req = '0;
        tick();
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
